data_mem_ctrl: RTL

- Parametrised, byte-addressable, big-endian data memory for the MEM stage. Successor to the flat combinational-read memory.
- Adds byte, half, word and (when DATA_W=64) doubleword access, with sign or zero extension on loads.
- Detects misaligned and out-of-range accesses and reports them as faults.
- Models a configurable access latency behind a valid/ready request and single-cycle response handshake, so the pipeline can exercise stall logic.

---
 rtl/data_mem_pkg.sv | 17 +
 rtl/mem_align_ext.sv | 51 +++++
 rtl/data_mem_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the byte-addressable, big-endian MEM-stage data memory.
package data_mem_pkg;

    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    function automatic logic [3:0] nbytes(input size_e size);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_ext.sv
// Request legality check (size/alignment/range) and big-endian load extraction with
// sign or zero extension.
module mem_align_ext
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic [ADDR_W-1:0] chk_addr,
    input  size_e             chk_size,
    output logic              chk_fault,
    input  size_e             ext_size,
    input  logic              ext_unsigned,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ext_data
);

    localparam int unsigned NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

    logic [3:0]        chk_nb;
    logic [ADDR_W:0]   chk_end;
    logic [3:0]        ext_nb;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] sign_vec;
    logic [DATA_W-1:0] mask;
    logic              sign;

    // nb-1 in three bits is the alignment mask; 8 bytes wraps 0-1 to 3'b111
    always_comb begin
        chk_nb    = nbytes(chk_size);
        chk_end   = {1'b0, chk_addr} + (ADDR_W + 1)'(chk_nb);
        chk_fault = ((chk_size == SZ_D) && (DATA_W == 32))
                 || ((chk_addr[2:0] & (chk_nb[2:0] - 3'd1)) != 3'd0)
                 || (chk_end > DEPTH_L);
    end

    // raw carries the bytes at addr.. MSB-first; the accessed field is its top ext_nb bytes
    always_comb begin
        ext_nb = nbytes(ext_size);
        if (ext_nb > 4'(NB)) ext_nb = 4'(NB);
        shifted  = raw >> (8 * (NB - 32'(ext_nb)));
        sign_vec = shifted >> (8 * 32'(ext_nb) - 1);
        sign     = ~ext_unsigned & sign_vec[0];
        if (ext_nb == 4'(NB)) mask = '1;
        else mask = (DATA_W'(1) << (8 * 32'(ext_nb))) - DATA_W'(1);
        ext_data = (shifted & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable big-endian data memory with fault detection and a configurable
// access latency behind a valid/ready request and one-cycle response strobe.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              busy
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned MW = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

    logic [7:0]        mem [DEPTH_BYTES];
    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              write_q;
    size_e             size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              chk_fault;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] wdata_msb;
    logic [7:0]        rd_byte;
    logic [3:0]        nb_q;
    logic              do_access;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign do_access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign nb_q      = nbytes(size_q);
    assign wdata_msb = wdata_q << (8 * (NB - 32'(nb_q)));

    // Gather NB bytes from addr_q upward, MSB-first; bytes past the end read as zero
    always_comb begin
        raw = '0;
        for (int k = 0; k < NB; k++) begin
            rd_byte = '0;
            if (({1'b0, addr_q} + (ADDR_W + 1)'(k)) < DEPTH_L) begin
                rd_byte = mem[addr_q[MW-1:0] + MW'(k)];
            end
            raw = (raw << 8) | DATA_W'(rd_byte);
        end
    end

    mem_align_ext #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_align_ext (
        .chk_addr     (req_addr),
        .chk_size     (size_e'(req_size)),
        .chk_fault    (chk_fault),
        .ext_size     (size_q),
        .ext_unsigned (uns_q),
        .raw          (raw),
        .ext_data     (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[MW'(i)] <= '0;
        end else if (do_access && write_q) begin
            for (int k = 0; k < NB; k++) begin
                if (k < int'(nb_q)) begin
                    mem[addr_q[MW-1:0] + MW'(k)] <= 8'(wdata_msb >> (DATA_W - 8 - 8 * k));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= size_e'(req_size);
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (chk_fault) begin
                            state_q    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(LATENCY);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= write_q ? '0 : ext_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
